// File: rtl/pwm_ctrl.sv
// pwm_ctrl - multi-channel edge-aligned PWM peripheral on the peripheral bus.
//
// NUM_CH PWM outputs share one prescaled 16-bit period counter. Duty values
// are double-buffered: the pending DUTY register is copied into the active
// compare value at each period wrap (or at once while disabled).
//
// Optional feature macro: PWM_IRQ_EN
//   defined   -> STATUS.WRAP sticky flag and registered irq_o = IRQ_EN & WRAP
//   undefined -> STATUS reads 0, irq_o tied low, no wrap-flag logic
//
// Ports:
//   clk_i, rst_n_i     clock, asynchronous active-low reset
//   addr_32b_i         byte address, [7:2] selects the register
//   wren_i / rden_i    single-cycle write / read request
//   din_32b_i, wstrb_i write data and byte strobes
//   dout_32b_valid_o   one-cycle response pulse per request (1 cycle latency)
//   dout_32b_o         read data, 0 when not a read response
//   pwm_o[NUM_CH]      registered PWM outputs
//   irq_o              level interrupt

package pwm_ctrl_pkg;
  // Byte-strobe merge for the 16-bit registers.
  function automatic logic [15:0] merge16(input logic [15:0] old,
                                          input logic [15:0] wd,
                                          input logic [1:0]  be);
    merge16 = old;
    if (be[0]) merge16[7:0]  = wd[7:0];
    if (be[1]) merge16[15:8] = wd[15:8];
  endfunction
endpackage

// One PWM channel: pending duty, active duty and the compare output.
module pwm_ch
  import pwm_ctrl_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        en_i,
  input  logic        load_i,   // period wrap: adopt pending duty
  input  logic        we_i,
  input  logic [15:0] wdata_i,
  input  logic [1:0]  wstrb_i,
  input  logic [15:0] cnt_i,
  output logic [15:0] duty_o,
  output logic        pwm_o
);
  logic [15:0] duty_q, duty_d, duty_act_q;
  logic        pwm_q;

  assign duty_d = we_i ? merge16(duty_q, wdata_i, wstrb_i) : duty_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      duty_q     <= '0;
      duty_act_q <= '0;
      pwm_q      <= 1'b0;
    end else begin
      duty_q <= duty_d;
      // While stopped the active value follows writes so the first period
      // after enabling already uses the new duty.
      if (!en_i)       duty_act_q <= duty_d;
      else if (load_i) duty_act_q <= duty_q;
      pwm_q <= en_i & (cnt_i < duty_act_q);
    end
  end

  assign duty_o = duty_q;
  assign pwm_o  = pwm_q;
endmodule

module pwm_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic [31:0]       addr_32b_i,
  input  logic              wren_i,
  input  logic              rden_i,
  input  logic [31:0]       din_32b_i,
  input  logic [3:0]        wstrb_i,
  output logic              dout_32b_valid_o,
  output logic [31:0]       dout_32b_o,
  output logic [NUM_CH-1:0] pwm_o,
  output logic              irq_o
);
  localparam logic [5:0] A_CTRL   = 6'd0;
  localparam logic [5:0] A_PERIOD = 6'd1;
  localparam logic [5:0] A_STATUS = 6'd2;
  localparam logic [5:0] A_PRESC  = 6'd3;

  logic [5:0]  widx;
  logic        en_q, irq_en_q;
  logic [15:0] period_q, presc_q, pcnt_q, cnt_q;
  logic        tick, wrap_evt;
  logic [31:0] rdata, status_rd;
  logic        valid_q;
  logic [31:0] dout_q;
  logic [NUM_CH-1:0]       duty_we;
  logic [NUM_CH-1:0][15:0] duty_all;

  logic unused_bits;
  assign unused_bits = ^{addr_32b_i[31:8], addr_32b_i[1:0],
                         din_32b_i[31:16], wstrb_i[3:2]};

  assign widx = addr_32b_i[7:2];

  // ---------------- control registers ----------------
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_q     <= 1'b0;
      irq_en_q <= 1'b0;
      period_q <= '0;
      presc_q  <= '0;
    end else if (wren_i) begin
      if (widx == A_CTRL && wstrb_i[0]) begin
        en_q     <= din_32b_i[0];
        irq_en_q <= din_32b_i[1];
      end
      if (widx == A_PERIOD) period_q <= merge16(period_q, din_32b_i[15:0], wstrb_i[1:0]);
      if (widx == A_PRESC)  presc_q  <= merge16(presc_q,  din_32b_i[15:0], wstrb_i[1:0]);
    end
  end

  // ---------------- prescaler + period counter ----------------
  assign tick = (pcnt_q == presc_q);
  // A counter that overshot a shrunken PERIOD wraps through 0xFFFF; that
  // rollover is a period boundary as well.
  assign wrap_evt = en_q & tick & ((cnt_q == period_q) | (cnt_q == 16'hFFFF));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      pcnt_q <= '0;
      cnt_q  <= '0;
    end else if (!en_q) begin
      pcnt_q <= '0;
      cnt_q  <= '0;
    end else if (tick) begin
      pcnt_q <= '0;
      cnt_q  <= (cnt_q == period_q) ? 16'h0 : cnt_q + 16'h1;
    end else begin
      pcnt_q <= pcnt_q + 16'h1;
    end
  end

  // ---------------- channels ----------------
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign duty_we[c] = wren_i & (widx == 6'(4 + c));
    pwm_ch u_ch (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .en_i    (en_q),
      .load_i  (wrap_evt),
      .we_i    (duty_we[c]),
      .wdata_i (din_32b_i[15:0]),
      .wstrb_i (wstrb_i[1:0]),
      .cnt_i   (cnt_q),
      .duty_o  (duty_all[c]),
      .pwm_o   (pwm_o[c])
    );
  end

  // ---------------- wrap status / interrupt ----------------
`ifdef PWM_IRQ_EN
  logic wrap_q, irq_q;
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wrap_q <= 1'b0;
      irq_q  <= 1'b0;
    end else begin
      // Set has priority over a simultaneous write-1-to-clear.
      if (wrap_evt)
        wrap_q <= 1'b1;
      else if (wren_i && widx == A_STATUS && wstrb_i[0] && din_32b_i[0])
        wrap_q <= 1'b0;
      irq_q <= irq_en_q & wrap_q;
    end
  end
  assign status_rd = {31'h0, wrap_q};
  assign irq_o     = irq_q;
`else
  assign status_rd = '0;
  assign irq_o     = 1'b0;
`endif

  // ---------------- read mux / response ----------------
  always_comb begin
    rdata = '0;
    case (widx)
      A_CTRL:   rdata = {30'h0, irq_en_q, en_q};
      A_PERIOD: rdata = {16'h0, period_q};
      A_STATUS: rdata = status_rd;
      A_PRESC:  rdata = {16'h0, presc_q};
      default: begin
        for (int c = 0; c < NUM_CH; c++)
          if (widx == 6'(4 + c)) rdata = {16'h0, duty_all[c]};
      end
    endcase
  end

  // Read data is sampled from the current (pre-write) register values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      valid_q <= wren_i | rden_i;
      dout_q  <= rden_i ? rdata : 32'h0;
    end
  end

  assign dout_32b_valid_o = valid_q;
  assign dout_32b_o       = dout_q;
endmodule

// File: tb/tb_pwm_ctrl.sv
module tb_pwm_ctrl;
  localparam int NUM_CH = 4;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic [31:0]       addr_32b_i;
  logic              wren_i, rden_i;
  logic [31:0]       din_32b_i;
  logic [3:0]        wstrb_i;
  logic              dout_32b_valid_o;
  logic [31:0]       dout_32b_o;
  logic [NUM_CH-1:0] pwm_o;
  logic              irq_o;

  int n_checks = 0;
  int n_fail   = 0;

  pwm_ctrl #(.NUM_CH(NUM_CH)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .addr_32b_i(addr_32b_i),
    .wren_i(wren_i), .rden_i(rden_i), .din_32b_i(din_32b_i), .wstrb_i(wstrb_i),
    .dout_32b_valid_o(dout_32b_valid_o), .dout_32b_o(dout_32b_o),
    .pwm_o(pwm_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL timeout: simulation still running, required finish");
    $fatal(1);
  end

  // Bus driver: request sampled at the next rising edge, response captured
  // 1 time unit after that edge.
  task automatic do_req(input logic wr, input logic rd, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output logic v, output logic [31:0] q);
    @(negedge clk_i);
    wren_i = wr; rden_i = rd; addr_32b_i = {24'h0, a}; din_32b_i = d; wstrb_i = s;
    @(posedge clk_i); #1;
    v = dout_32b_valid_o; q = dout_32b_o;
    wren_i = 1'b0; rden_i = 1'b0;
  endtask

  task automatic wr32(input logic [7:0] a, input logic [31:0] d);
    logic v; logic [31:0] q;
    do_req(1'b1, 1'b0, a, d, 4'hF, v, q);
  endtask

  task automatic test_reset;
    logic v; logic [31:0] q;
    n_checks++;
    if (pwm_o !== '0 || irq_o !== 1'b0 || dout_32b_valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got pwm=%h irq=%b vld=%b required 0 0 0", pwm_o, irq_o, dout_32b_valid_o);
    end
    for (int a = 0; a < 32; a += 4) begin
      do_req(1'b0, 1'b1, 8'(a), 32'h0, 4'h0, v, q);
      n_checks++;
      if (v !== 1'b1 || q !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_read_%0h: got vld=%b data=%h required vld=1 data=0", a, v, q);
      end
    end
  endtask

  task automatic test_basic_pwm;
    logic [19:0] obs, expv;
    wr32(8'h04, 32'd9);
    wr32(8'h10, 32'd3);
    wr32(8'h00, 32'h1);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk_i); #1;
      obs[k]  = pwm_o[0];
      expv[k] = ((k % 10) < 3);
    end
    n_checks++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL basic_pwm0: got %b required %b", obs, expv);
    end
  endtask

  task automatic test_prescaler;
    logic [19:0] o1, o2, o3, e3;
    wr32(8'h00, 32'h0);
    wr32(8'h0C, 32'd1);
    wr32(8'h04, 32'd4);
    wr32(8'h14, 32'd0);
    wr32(8'h18, 32'd6);
    wr32(8'h1C, 32'd1);
    wr32(8'h00, 32'h1);
    for (int k = 0; k < 20; k++) begin
      @(posedge clk_i); #1;
      o1[k] = pwm_o[1]; o2[k] = pwm_o[2]; o3[k] = pwm_o[3];
      e3[k] = ((k % 10) < 2);
    end
    n_checks++;
    if (o1 !== 20'h0) begin n_fail++; $display("FAIL presc_duty0_low: got %b required %b", o1, 20'h0); end
    n_checks++;
    if (o2 !== 20'hFFFFF) begin n_fail++; $display("FAIL presc_duty_gt_period_high: got %b required %b", o2, 20'hFFFFF); end
    n_checks++;
    if (o3 !== e3) begin n_fail++; $display("FAIL presc_cnt_rate: got %b required %b", o3, e3); end
  endtask

  task automatic test_duty_update;
    logic v; logic [31:0] q;
    logic [19:0] obs, expv;
    wr32(8'h00, 32'h0);
    wr32(8'h0C, 32'd0);
    wr32(8'h04, 32'd9);
    wr32(8'h10, 32'd3);
    wr32(8'h00, 32'h1);
    wr32(8'h10, 32'd7);
    do_req(1'b0, 1'b1, 8'h10, 32'h0, 4'h0, v, q);
    n_checks++;
    if (q !== 32'd7) begin n_fail++; $display("FAIL duty_pending_read: got %h required %h", q, 32'd7); end
    for (int k = 2; k < 22; k++) begin
      @(posedge clk_i); #1;
      obs[k-2]  = pwm_o[0];
      expv[k-2] = (k < 10) ? (k < 3) : ((k % 10) < 7);
    end
    n_checks++;
    if (obs !== expv) begin n_fail++; $display("FAIL duty_double_buffer: got %b required %b", obs, expv); end
  endtask

  task automatic test_irq;
    logic v; logic [31:0] q;
    int k;
    wr32(8'h00, 32'h0);
    wr32(8'h0C, 32'd0);
    wr32(8'h04, 32'd4);
`ifdef PWM_IRQ_EN
    wr32(8'h08, 32'h1);
    do_req(1'b0, 1'b1, 8'h08, 32'h0, 4'h0, v, q);
    n_checks++;
    if (q !== 32'h0) begin n_fail++; $display("FAIL irq_status_cleared: got %h required 0", q); end
    wr32(8'h00, 32'h3);
    k = 0;
    while (!irq_o && k < 20) begin @(posedge clk_i); #1; k++; end
    n_checks++;
    if (k != 6) begin n_fail++; $display("FAIL irq_first_rise: got %0d cycles required 6", k); end
    wr32(8'h08, 32'h1);
    @(posedge clk_i); #1;
    n_checks++;
    if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_clear_drop: got %b required 0", irq_o); end
    k = 0;
    while (!irq_o && k < 20) begin @(posedge clk_i); #1; k++; end
    n_checks++;
    if (k != 3) begin n_fail++; $display("FAIL irq_rerise: got %0d cycles required 3", k); end
    wr32(8'h08, 32'h1);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    n_checks++;
    if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_low_before_wrap: got %b required 0", irq_o); end
    wr32(8'h08, 32'h1);  // lands in the wrap cycle
    do_req(1'b0, 1'b1, 8'h08, 32'h0, 4'h0, v, q);
    n_checks++;
    if (q !== 32'h1 || irq_o !== 1'b1) begin
      n_fail++; $display("FAIL irq_set_wins: got status=%h irq=%b required 1 1", q, irq_o);
    end
`else
    wr32(8'h00, 32'h3);
    repeat (15) @(posedge clk_i);
    #1;
    n_checks++;
    if (irq_o !== 1'b0) begin n_fail++; $display("FAIL irq_tied_low: got %b required 0", irq_o); end
    do_req(1'b0, 1'b1, 8'h08, 32'h0, 4'h0, v, q);
    n_checks++;
    if (q !== 32'h0) begin n_fail++; $display("FAIL status_absent: got %h required 0", q); end
`endif
    wr32(8'h00, 32'h0);
  endtask

  task automatic test_bytes;
    logic v; logic [31:0] q;
    wr32(8'h10, 32'h0000_0012);
    do_req(1'b1, 1'b0, 8'h10, 32'h0000_AB00, 4'b0010, v, q);
    do_req(1'b0, 1'b1, 8'h10, 32'h0, 4'h0, v, q);
    n_checks++;
    if (q !== 32'h0000_AB12) begin n_fail++; $display("FAIL byte_strobe: got %h required %h", q, 32'h0000_AB12); end
    wr32(8'h14, 32'hFFFF_FFFF);
    do_req(1'b0, 1'b1, 8'h14, 32'h0, 4'h0, v, q);
    n_checks++;
    if (q !== 32'h0000_FFFF) begin n_fail++; $display("FAIL unused_bits: got %h required %h", q, 32'h0000_FFFF); end
    do_req(1'b1, 1'b0, 8'h40, 32'hFFFF_FFFF, 4'hF, v, q);
    n_checks++;
    if (v !== 1'b1 || q !== 32'h0) begin n_fail++; $display("FAIL unmapped_write_resp: got vld=%b data=%h required 1 0", v, q); end
    do_req(1'b0, 1'b1, 8'h40, 32'h0, 4'h0, v, q);
    n_checks++;
    if (v !== 1'b1 || q !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got vld=%b data=%h required 1 0", v, q); end
    do_req(1'b1, 1'b0, 8'h04, 32'h0000_1234, 4'h0, v, q);
    n_checks++;
    if (v !== 1'b1) begin n_fail++; $display("FAIL zero_strobe_resp: got vld=%b required 1", v); end
    do_req(1'b0, 1'b1, 8'h04, 32'h0, 4'h0, v, q);
    n_checks++;
    if (q !== 32'd4) begin n_fail++; $display("FAIL zero_strobe_nochange: got %h required %h", q, 32'd4); end
  endtask

  task automatic test_rw_same;
    logic v; logic [31:0] q;
    do_req(1'b1, 1'b1, 8'h04, 32'h55, 4'hF, v, q);
    n_checks++;
    if (v !== 1'b1 || q !== 32'd4) begin n_fail++; $display("FAIL rw_prewrite: got vld=%b data=%h required 1 %h", v, q, 32'd4); end
    do_req(1'b0, 1'b1, 8'h04, 32'h0, 4'h0, v, q);
    n_checks++;
    if (q !== 32'h55) begin n_fail++; $display("FAIL rw_written: got %h required %h", q, 32'h55); end
  endtask

  task automatic test_back_to_back;
    logic v1, v2, v3; logic [31:0] d1, d2, d3;
    @(negedge clk_i);
    rden_i = 1'b1; addr_32b_i = 32'h04;
    @(posedge clk_i); #1;
    v1 = dout_32b_valid_o; d1 = dout_32b_o;
    addr_32b_i = 32'h10;
    @(posedge clk_i); #1;
    v2 = dout_32b_valid_o; d2 = dout_32b_o;
    rden_i = 1'b0;
    @(posedge clk_i); #1;
    v3 = dout_32b_valid_o; d3 = dout_32b_o;
    n_checks++;
    if (v1 !== 1'b1 || d1 !== 32'h55) begin n_fail++; $display("FAIL b2b_first: got vld=%b data=%h required 1 %h", v1, d1, 32'h55); end
    n_checks++;
    if (v2 !== 1'b1 || d2 !== 32'h0000_AB12) begin n_fail++; $display("FAIL b2b_second: got vld=%b data=%h required 1 %h", v2, d2, 32'h0000_AB12); end
    n_checks++;
    if (v3 !== 1'b0 || d3 !== 32'h0) begin n_fail++; $display("FAIL b2b_idle: got vld=%b data=%h required 0 0", v3, d3); end
  endtask

  task automatic test_reset_mid;
    logic v; logic [31:0] q;
    wr32(8'h04, 32'd9);
    wr32(8'h10, 32'd5);
    wr32(8'h00, 32'h1);
    @(posedge clk_i); #1;
    n_checks++;
    if (pwm_o[0] !== 1'b1) begin n_fail++; $display("FAIL pre_reset_high: got %b required 1", pwm_o[0]); end
    #2;
    rst_n_i = 1'b0;
    #1;
    n_checks++;
    if (pwm_o !== '0 || irq_o !== 1'b0) begin n_fail++; $display("FAIL async_reset: got pwm=%h irq=%b required 0 0", pwm_o, irq_o); end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    do_req(1'b0, 1'b1, 8'h10, 32'h0, 4'h0, v, q);
    n_checks++;
    if (q !== 32'h0) begin n_fail++; $display("FAIL reset_clears_duty: got %h required 0", q); end
  endtask

  initial begin
    rst_n_i = 1'b0; wren_i = 1'b0; rden_i = 1'b0;
    addr_32b_i = '0; din_32b_i = '0; wstrb_i = '0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    test_reset;
    test_basic_pwm;
    test_prescaler;
    test_duty_update;
    test_irq;
    test_bytes;
    test_rw_same;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
